// File: rtl/log_expand_pkg.sv
// Shared constants, the 2^(k/32) reference table and FSM state encoding for log_expand.
package log_expand_pkg;

    localparam int FRAC_W  = 16;
    localparam int IDX_W   = 5;
    localparam int DELTA_W = 11;
    localparam int LUT_W   = 18;
    localparam int LUT_N   = 33;

    // T[k] = round(2^(k/32) * 65536), k = 0..32, unsigned Q1.16
    localparam logic [LUT_W-1:0] T_TABLE [LUT_N] = '{
        18'd65536,  18'd66971,  18'd68438,  18'd69936,
        18'd71468,  18'd73032,  18'd74632,  18'd76266,
        18'd77936,  18'd79642,  18'd81386,  18'd83169,
        18'd84990,  18'd86851,  18'd88752,  18'd90696,
        18'd92682,  18'd94711,  18'd96785,  18'd98905,
        18'd101070, 18'd103283, 18'd105545, 18'd107856,
        18'd110218, 18'd112631, 18'd115098, 18'd117618,
        18'd120194, 18'd122825, 18'd125515, 18'd128263,
        18'd131072
    };

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LUT    = 3'd1,
        INTERP = 3'd2,
        SHIFT  = 3'd3,
        HOLD   = 3'd4
    } state_e;

endpackage

// File: rtl/exp2_frac_lut.sv
// Returns the two neighbouring 2^(k/32) table entries that bracket a fraction index.
module exp2_frac_lut
    import log_expand_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    output logic [LUT_W-1:0] y0_o,
    output logic [LUT_W-1:0] y1_o
);

    logic [IDX_W:0] idx_next;

    assign idx_next = {1'b0, idx_i} + (IDX_W+1)'(1);
    assign y0_o     = T_TABLE[idx_i];
    assign y1_o     = T_TABLE[idx_next];

endmodule

// File: rtl/log_expand.sv
// Converts a log2 value (integer + Q1.16 fraction) back to a linear sample using a
// 33-entry table with linear interpolation; one sample in flight, held until consumed.
// Handshake: a transfer happens on a rising edge with valid and ready both high;
// the producer keeps its data steady while valid is high and ready is low.
module log_expand
    import log_expand_pkg::*;
#(
    parameter int DATA_WIDTH  = 48,
    parameter int FRAC_WIDTH  = 16,
    parameter int NORM_WIDTH  = FRAC_WIDTH + 1,
    parameter int SHIFT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   log_valid,
    input  logic [SHIFT_WIDTH-1:0] comp_int,
    input  logic [NORM_WIDTH-1:0]  comp_frac,
    output logic                   log_ready,
    output logic [DATA_WIDTH-1:0]  data_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output state_e                 dbg_state
);

    localparam int E_W    = SHIFT_WIDTH + 1;
    localparam int WIDE_W = DATA_WIDTH + LUT_W;

    if (FRAC_WIDTH != FRAC_W) begin : g_bad_frac_width
        $fatal(1, "log_expand: FRAC_WIDTH must be 16");
    end

    state_e                  state_q, state_d;
    logic [E_W-1:0]          e_q, e_d;
    logic [FRAC_W-1:0]       f_q, f_d;
    logic [LUT_W-1:0]        y0_q, y0_d, y1_q, y1_d;
    logic [LUT_W-1:0]        m_q, m_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;

    logic [LUT_W-1:0]         lut_y0, lut_y1;
    logic [LUT_W-1:0]         delta;
    logic [LUT_W+DELTA_W-1:0] prod;
    logic [WIDE_W-1:0]        wide, shifted;
    logic                     sat;

    exp2_frac_lut u_lut (
        .idx_i (f_q[FRAC_W-1 -: IDX_W]),
        .y0_o  (lut_y0),
        .y1_o  (lut_y1)
    );

    // Table is monotonic, so delta never goes negative.
    always_comb begin
        delta   = y1_q - y0_q;
        prod    = {{DELTA_W{1'b0}}, delta} * {{LUT_W{1'b0}}, f_q[DELTA_W-1:0]};
        wide    = {{DATA_WIDTH{1'b0}}, m_q} << e_q;
        shifted = wide >> FRAC_W;
        sat     = (e_q >= E_W'(DATA_WIDTH)) || (|shifted[WIDE_W-1:DATA_WIDTH]);
    end

    always_comb begin
        state_d = state_q;
        e_d     = e_q;
        f_d     = f_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
        m_d     = m_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (log_valid) begin
                    e_d     = {1'b0, comp_int} + E_W'(comp_frac[NORM_WIDTH-1]);
                    f_d     = comp_frac[FRAC_W-1:0];
                    state_d = LUT;
                end
            end
            LUT: begin
                y0_d    = lut_y0;
                y1_d    = lut_y1;
                state_d = INTERP;
            end
            INTERP: begin
                m_d     = y0_q + LUT_W'(prod >> DELTA_W);
                state_d = SHIFT;
            end
            SHIFT: begin
                data_d  = sat ? {DATA_WIDTH{1'b1}} : shifted[DATA_WIDTH-1:0];
                state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            e_q     <= '0;
            f_q     <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            m_q     <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            e_q     <= e_d;
            f_q     <= f_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            m_q     <= m_d;
            data_q  <= data_d;
        end
    end

    assign log_ready = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign data_out  = data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_log_expand.sv
// Self-checking bench for log_expand: vector table, corner sequences, sweep and random traffic.
module tb_log_expand;
    import log_expand_pkg::*;

    localparam logic [47:0] ONES = '1;

    logic        clk = 1'b0;
    logic        reset;
    logic        log_valid;
    logic [5:0]  comp_int;
    logic [16:0] comp_frac;
    logic        log_ready;
    logic [47:0] data_out;
    logic        out_valid;
    logic        out_ready;
    state_e      dbg_state;

    log_expand dut (
        .clk       (clk),
        .reset     (reset),
        .log_valid (log_valid),
        .comp_int  (comp_int),
        .comp_frac (comp_frac),
        .log_ready (log_ready),
        .data_out  (data_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_in = 0;
    int          n_out = 0;
    int          n_flushed = 0;
    logic [47:0] exp_q[$];
    real         exact_q[$];
    logic [47:0] last_out;
    logic [47:0] mon_exp;
    real         mon_x;
    real         mon_err;
    longint unsigned tb_t[33];
    bit          bp_on;

    typedef struct {
        int unsigned ci;
        int unsigned cf;
        logic [47:0] exp;
    } vec_t;
    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [47:0] model(input int unsigned ci, input int unsigned cf);
        int unsigned     e, f, idx, d;
        longint unsigned y0, y1, m;
        logic [127:0]    v;
        e   = ci + ((cf >> 16) & 1);
        f   = cf & 32'hFFFF;
        idx = f >> 11;
        d   = f & 32'h7FF;
        y0  = tb_t[idx];
        y1  = tb_t[idx+1];
        m   = y0 + (((y1 - y0) * d) >> 11);
        if (e >= 48) return ONES;
        v = 128'(m) << e;
        v = v >> 16;
        if (v > 128'hFFFF_FFFF_FFFF) return ONES;
        return v[47:0];
    endfunction

    // Scoreboard: every accepted output is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            n_out++;
            last_out = data_out;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got %0d, expected no output", data_out);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_x   = exact_q.pop_front();
                check("data_out", 64'(data_out), 64'(mon_exp));
                if (mon_x >= 0.0) begin
                    n_cmp++;
                    mon_err = real'(data_out) - mon_x;
                    if (mon_err < 0.0) mon_err = -mon_err;
                    if (mon_err > mon_x / 4096.0 + 1.0) begin
                        n_bad++;
                        $display("FAIL accuracy: got %0d, exact %f", data_out, mon_x);
                    end
                end
            end
        end
    end

    task automatic send(input int unsigned ci, input int unsigned cf,
                        input logic [47:0] exp, input real exact);
        int n = 0;
        while (!log_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!log_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: got log_ready=0, expected 1 within 100 cycles");
            return;
        end
        comp_int  = ci[5:0];
        comp_frac = cf[16:0];
        log_valid = 1'b1;
        exp_q.push_back(exp);
        exact_q.push_back(exact);
        n_in++;
        @(posedge clk); #1;
        log_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
        end
    endtask

    initial begin
        int          cnt;
        logic [47:0] exp_bp;

        reset     = 1'b1;
        log_valid = 1'b0;
        comp_int  = '0;
        comp_frac = '0;
        out_ready = 1'b1;
        bp_on     = 1'b0;
        for (int k = 0; k < 33; k++)
            tb_t[k] = longint'($floor(65536.0 * (2.0 ** (real'(k) / 32.0)) + 0.5));

        vecs[0]  = '{0,  32'h00000, 48'd1};
        vecs[1]  = '{16, 32'h00000, 48'd65536};
        vecs[2]  = '{3,  32'h08000, 48'd11};
        vecs[3]  = '{50, 32'h01234, ONES};
        vecs[4]  = '{47, 32'h10000, ONES};
        vecs[5]  = '{47, 32'h00000, 48'd140737488355328};
        vecs[6]  = '{0,  32'h10000, 48'd2};
        vecs[7]  = '{10, 32'h00800, 48'd1046};
        vecs[8]  = '{5,  32'h1FFFF, 48'd127};
        vecs[9]  = '{63, 32'h00000, ONES};
        vecs[10] = '{40, 32'h0FFFF, 48'd2198989701120};
        vecs[11] = '{4,  32'h00400, 48'd16};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("in_reset_data_out", 64'(data_out), 64'd0);
        check("in_reset_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_log_ready", 64'(log_ready), 64'd1);
        check("post_reset_out_valid", 64'(out_valid), 64'd0);
        check("post_reset_data_out", 64'(data_out), 64'd0);

        // Output must rise exactly after LUT, INTERP and SHIFT cycles.
        send(0, 0, 48'd1, -1.0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("latency_low", 64'(out_valid), 64'd0);
        end
        @(negedge clk);
        check("latency_high", 64'(out_valid), 64'd1);
        drain();

        for (int i = 0; i < 12; i++)
            send(vecs[i].ci, vecs[i].cf, vecs[i].exp, -1.0);
        drain();

        send(29, 57633, model(29, 57633), -1.0);
        drain();
        n_cmp++;
        if (last_out < 48'd987413191 || last_out > 48'd987895451) begin
            n_bad++;
            $display("FAIL tol_29_57633: got %0d, expected 987654321 +/- 241130", last_out);
        end

        // Backpressure: output held while downstream stalls and upstream keeps pushing.
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_bp = model(7, 32'h3456);
        send(7, 32'h3456, exp_bp, -1.0);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!out_valid && cnt < 20);
        check("bp_out_valid", 64'(out_valid), 64'd1);
        log_valid = 1'b1;
        comp_int  = 6'd9;
        comp_frac = 17'h01111;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_data_stable", 64'(data_out), 64'(exp_bp));
            check("bp_log_ready", 64'(log_ready), 64'd0);
            check("bp_out_valid_held", 64'(out_valid), 64'd1);
        end
        @(posedge clk); #1;
        log_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset while the sample is in INTERP discards it.
        send(12, 32'h2222, model(12, 32'h2222), -1.0);
        @(posedge clk); #1;
        check("state_interp", 64'(dbg_state), 64'(INTERP));
        reset = 1'b1;
        exp_q.delete();
        exact_q.delete();
        n_flushed++;
        @(negedge clk);
        check("mid_reset_out_valid", 64'(out_valid), 64'd0);
        check("mid_reset_data_out", 64'(data_out), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rel_out_valid", 64'(out_valid), 64'd0);
        check("rel_data_out", 64'(data_out), 64'd0);
        check("rel_log_ready", 64'(log_ready), 64'd1);
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (out_valid) cnt++;
        end
        check("no_stale_pulse", 64'(cnt), 64'd0);
        send(3, 32'h8000, 48'd11, -1.0);
        drain();

        // Sparse fraction sweep at comp_int=20 with accuracy bound.
        for (int cf = 0; cf < 65536; cf += 97)
            send(20, cf, model(20, cf), 2.0 ** (20.0 + real'(cf) / 65536.0));
        send(20, 65535, model(20, 65535), 2.0 ** (20.0 + 65535.0 / 65536.0));
        drain();

        // Random traffic under random downstream stalls.
        bp_on = 1'b1;
        fork
            begin
                int unsigned ci, cf;
                for (int i = 0; i < 150; i++) begin
                    ci = $urandom_range(0, 50);
                    cf = $urandom_range(0, 131071);
                    send(ci, cf, model(ci, cf), -1.0);
                end
                bp_on = 1'b0;
            end
            begin
                while (bp_on) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        check("in_out_count", 64'(n_out), 64'(n_in - n_flushed));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
